// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_sub_state_t;

    localparam int SUB_WIDTH = 4;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell, the subtracting counterpart of the adder's full-adder cell.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a < b, or when a == b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: x - y - bin over WIDTH cycles, LSB first, start/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; diff/bout hold the last result
//   SHIFT | one operand bit pair processed per cycle, busy=1
//   DONE  | single-cycle done pulse; start here is accepted as in IDLE
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TC = CW'(WIDTH - 1);

    serial_sub_state_t state_q, state_d;
    logic [WIDTH-1:0]  xs_q, xs_d;
    logic [WIDTH-1:0]  ys_q, ys_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              br_q, br_d;
    logic              bout_q, bout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic d_bit;
    logic br_next;

    full_sub u_full_sub (
        .a    (xs_q[0]),
        .b    (ys_q[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (br_next)
    );

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        work_d  = work_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    br_d    = bin;
                    cnt_d   = '0;
                    work_d  = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                work_d = {d_bit, work_q[WIDTH-1:1]};
                xs_d   = xs_q >> 1;
                ys_d   = ys_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_TC) begin
                    diff_d  = {d_bit, work_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            work_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            work_q  <= work_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH=4: directed table, corner sequences, exhaustive and random ops.
module tb_serial_sub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int tests_run = 0;
    int tests_failed = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] vx;
        logic [W-1:0] vy;
        logic         vbin;
        logic [W-1:0] ediff;
        logic         ebout;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned operands.
    function automatic int ref_diff(input int a, input int b, input int c);
        return (a - b - c + 2 * (1 << W)) % (1 << W);
    endfunction

    function automatic int ref_bout(input int a, input int b, input int c);
        return (a < b + c) ? 1 : 0;
    endfunction

    function automatic int ripple_carry(input int a, input int b, input int c);
        return (a + b + c) % (1 << W);
    endfunction

    // Issues one operation; optionally scrambles the inputs (start low) while it runs.
    task automatic do_op(input logic [W-1:0] ox, input logic [W-1:0] oy, input logic ob,
                         input bit scramble, output int busy_cnt, output int lat, output bit seen);
        int k;
        @(negedge clk);
        start = 1'b1; x = ox; y = oy; bin = ob;
        busy_cnt = 0; lat = 0; seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (scramble) begin
                x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
            end
            if (busy) busy_cnt++;
            if (done) begin
                lat = k - 1;
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int bc, lat, k, k2, ndone;
        bit seen;

        vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0};
        vecs[1] = '{4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
        vecs[3] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0};

        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        check("reset_bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_op(vecs[i].vx, vecs[i].vy, vecs[i].vbin, 1'b1, bc, lat, seen);
            check($sformatf("vec%0d_done_seen", i), seen, 1);
            check($sformatf("vec%0d_diff", i), diff, vecs[i].ediff);
            check($sformatf("vec%0d_bout", i), bout, vecs[i].ebout);
            check($sformatf("vec%0d_busy_cycles", i), bc, W);
            check($sformatf("vec%0d_latency", i), lat, W);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse_width", i), done, 0);
        end

        // diff must hold the last (zero) result through idle cycles with noisy inputs.
        for (int i = 0; i < 10; i++) begin
            x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
            @(negedge clk);
            check($sformatf("hold_diff_%0d", i), diff, 0);
            check($sformatf("hold_bout_%0d", i), bout, 0);
        end

        // start held high during SHIFT with changing operands, then back-to-back from DONE.
        @(negedge clk);
        start = 1'b1; x = 4'b0101; y = 4'b0011; bin = 1'b0;
        seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
        end
        check("held_start_done_seen", seen, 1);
        check("held_start_latency", k - 1, W);
        check("held_start_diff", diff, 2);
        check("held_start_bout", bout, 0);
        x = 4'b0011; y = 4'b0101; bin = 1'b0;
        seen = 1'b0;
        for (k2 = 1; k2 <= 20; k2++) begin
            @(negedge clk);
            start = 1'b0;
            x = W'($urandom); y = W'($urandom);
            if (done) begin seen = 1'b1; break; end
        end
        check("b2b_done_seen", seen, 1);
        check("b2b_spacing", k2, W + 1);
        check("b2b_diff", diff, 14);
        check("b2b_bout", bout, 1);

        // Reset two cycles into an operation.
        @(negedge clk);
        start = 1'b1; x = 4'b1001; y = 4'b0010; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_diff", diff, 0);
        check("midreset_bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("post_reset_no_activity", ndone, 0);

        // Exhaustive over all operand/borrow combinations.
        for (int xi = 0; xi < (1 << W); xi++)
            for (int yi = 0; yi < (1 << W); yi++)
                for (int bi = 0; bi < 2; bi++) begin
                    do_op(W'(xi), W'(yi), 1'(bi), 1'b0, bc, lat, seen);
                    check($sformatf("ex_seen_%0d_%0d_%0d", xi, yi, bi), seen, 1);
                    check($sformatf("ex_diff_%0d_%0d_%0d", xi, yi, bi), diff, ref_diff(xi, yi, bi));
                    check($sformatf("ex_bout_%0d_%0d_%0d", xi, yi, bi), bout, ref_bout(xi, yi, bi));
                    if (bout == 1'b0)
                        check($sformatf("ex_adder_%0d_%0d_%0d", xi, yi, bi),
                              ripple_carry(yi, int'(diff), bi), xi);
                end

        // Random operations with random idle gaps and input noise.
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] rx, ry;
            logic         rb;
            int           gap;
            rx = W'($urandom); ry = W'($urandom); rb = 1'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                x = W'($urandom); y = W'($urandom);
            end
            do_op(rx, ry, rb, 1'b1, bc, lat, seen);
            check($sformatf("rnd%0d_seen", i), seen, 1);
            check($sformatf("rnd%0d_lat", i), lat, W);
            check($sformatf("rnd%0d_diff", i), diff, ref_diff(int'(rx), int'(ry), int'(rb)));
            check($sformatf("rnd%0d_bout", i), bout, ref_bout(int'(rx), int'(ry), int'(rb)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
